// File: rtl/alt_vipcts131_csr_pkg.sv
// rtl/alt_vipcts131_csr_pkg.sv - shared address map, decode type and byte merge helper for the CSR bank
// Purpose: common constants for alt_vipcts131_common_avalon_mm_csr_bank and alt_vipcts131_csr_reg.
// Contents:
//   CSR_ADDR_CTRL/STATUS/ISR/USER_BASE  word addresses of the register map
//   csr_sel_e                            decoded target of an Avalon-MM access
//   csr_merge_byte                       byte-lane merge used for byte-enabled writes
package alt_vipcts131_csr_pkg;

  localparam logic [31:0] CSR_ADDR_CTRL      = 32'd0;
  localparam logic [31:0] CSR_ADDR_STATUS    = 32'd1;
  localparam logic [31:0] CSR_ADDR_ISR       = 32'd2;
  localparam logic [31:0] CSR_ADDR_USER_BASE = 32'd3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_ISR,
    SEL_USER
  } csr_sel_e;

  function automatic logic [7:0] csr_merge_byte(input logic [7:0] old_byte,
                                                input logic [7:0] new_byte,
                                                input logic       lane_en);
    return lane_en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/alt_vipcts131_csr_reg.sv
// rtl/alt_vipcts131_csr_reg.sv - one user register: byte-enabled master write, internal write, optional shadow, trigger
// Purpose: storage for a single user register of the CSR bank.
// Configuration macro: CSR_SHADOW_EN (master writes go to a shadow copy, commit moves it to the active copy).
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   wr_en/wr_data/wr_be master write strobe, data and byte lanes (already address-decoded)
//   int_wr/int_data     internal full-word write (only honoured when ALLOW_INTERNAL_WRITE)
//   commit              frame-boundary copy strobe (shadow build only)
//   active              value driven to the core
//   rd_value            value returned on a master read
//   trigger             one-cycle pulse after each master write
module alt_vipcts131_csr_reg
  import alt_vipcts131_csr_pkg::*;
#(
  parameter int W                    = 32,
  parameter bit ALLOW_INTERNAL_WRITE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [W-1:0]   wr_data,
  input  logic [W/8-1:0] wr_be,
  input  logic           int_wr,
  input  logic [W-1:0]   int_data,
  input  logic           commit,
  output logic [W-1:0]   active,
  output logic [W-1:0]   rd_value,
  output logic           trigger
);

  logic         int_hit;
  logic [W-1:0] master_val;
  logic         trigger_q, trigger_d;

  assign int_hit = ALLOW_INTERNAL_WRITE && int_wr;

`ifdef CSR_SHADOW_EN
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] active_q, active_d;

  always_comb begin
    for (int b = 0; b < W/8; b++) begin
      master_val[b*8 +: 8] = csr_merge_byte(shadow_q[b*8 +: 8], wr_data[b*8 +: 8], wr_be[b]);
    end
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d = master_val;
    end else if (int_hit) begin
      shadow_d = int_data;
    end
    // Commit samples the shadow before this cycle's master write lands in it.
    active_d = active_q;
    if (int_hit) begin
      active_d = int_data;
    end else if (commit) begin
      active_d = shadow_q;
    end
    trigger_d = wr_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      trigger_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      trigger_q <= trigger_d;
    end
  end

  assign active   = active_q;
  assign rd_value = shadow_q;
`else
  logic [W-1:0] value_q, value_d;
  logic         unused_commit;

  assign unused_commit = commit;

  always_comb begin
    for (int b = 0; b < W/8; b++) begin
      master_val[b*8 +: 8] = csr_merge_byte(value_q[b*8 +: 8], wr_data[b*8 +: 8], wr_be[b]);
    end
    value_d = value_q;
    if (wr_en) begin
      value_d = master_val;
    end else if (int_hit) begin
      value_d = int_data;
    end
    trigger_d = wr_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q   <= '0;
      trigger_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      trigger_q <= trigger_d;
    end
  end

  assign active   = value_q;
  assign rd_value = value_q;
`endif

  assign trigger = trigger_q;

endmodule

// File: rtl/alt_vipcts131_common_avalon_mm_csr_bank.sv
// rtl/alt_vipcts131_common_avalon_mm_csr_bank.sv - Avalon-MM control/status register bank for VIP cores
// Purpose: CTRL (go + irq enables), STATUS (pending + stopped), W1C ISR and NO_REGISTERS user registers.
// Configuration macro: CSR_SHADOW_EN (user registers are double-buffered and committed at frame boundaries).
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   av_address/read/write/...     Avalon-MM slave, registered read data with readdatavalid, no waitrequest
//   av_irq                        OR of pending enabled interrupts
//   enable, clear_enable          go bit and its internal clear
//   commit                        frame-boundary shadow copy strobe
//   triggers                      per-register pulse after a master write
//   registers                     active register values, register i at [i*W +: W]
//   registers_in/registers_write  internal write path
//   interrupts                    interrupt sources captured into ISR
//   stopped                       per-output stopped flags, ANDed into STATUS[0]
module alt_vipcts131_common_avalon_mm_csr_bank
  import alt_vipcts131_csr_pkg::*;
#(
  parameter int AV_ADDRESS_WIDTH     = 5,
  parameter int AV_DATA_WIDTH        = 32,
  parameter int NO_OUTPUTS           = 1,
  parameter int NO_INTERRUPTS        = 1,
  parameter int NO_REGISTERS         = 4,
  parameter int ALLOW_INTERNAL_WRITE = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [AV_ADDRESS_WIDTH-1:0]           av_address,
  input  logic                                  av_read,
  output logic [AV_DATA_WIDTH-1:0]              av_readdata,
  output logic                                  av_readdatavalid,
  input  logic                                  av_write,
  input  logic [AV_DATA_WIDTH-1:0]              av_writedata,
  input  logic [AV_DATA_WIDTH/8-1:0]            av_byteenable,
  output logic                                  av_irq,
  output logic                                  enable,
  input  logic                                  clear_enable,
  input  logic                                  commit,
  output logic [NO_REGISTERS-1:0]               triggers,
  output logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers,
  input  logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers_in,
  input  logic [NO_REGISTERS-1:0]               registers_write,
  input  logic [NO_INTERRUPTS-1:0]              interrupts,
  input  logic [NO_OUTPUTS-1:0]                 stopped
);

  localparam int W = AV_DATA_WIDTH;

  logic [31:0]              addr_w;
  csr_sel_e                 sel;
  logic [NO_REGISTERS-1:0]  user_hit;
  logic                     ctrl_wr, isr_wr, user_wr;
  logic [W-1:0]             reg_rd [NO_REGISTERS];

  logic                     go_q, go_d;
  logic [NO_INTERRUPTS:1]   irq_en_q, irq_en_d;
  logic [NO_INTERRUPTS:1]   isr_q, isr_d;
  logic                     pending_q, pending_d;
  logic [W-1:0]             rdata_q, rdata_d;
  logic                     rvalid_q, rvalid_d;

  assign addr_w = 32'(av_address);

  always_comb begin
    user_hit = '0;
    for (int i = 0; i < NO_REGISTERS; i++) begin
      user_hit[i] = (addr_w == CSR_ADDR_USER_BASE + 32'(i));
    end
    if (addr_w == CSR_ADDR_CTRL)        sel = SEL_CTRL;
    else if (addr_w == CSR_ADDR_STATUS) sel = SEL_STATUS;
    else if (addr_w == CSR_ADDR_ISR)    sel = SEL_ISR;
    else if (|user_hit)                 sel = SEL_USER;
    else                                sel = SEL_NONE;
  end

  assign ctrl_wr = av_write && (sel == SEL_CTRL);
  assign isr_wr  = av_write && (sel == SEL_ISR);
  assign user_wr = av_write && (sel == SEL_USER);

  always_comb begin
    // A master write to lane 0 is applied after clear_enable so it wins the race.
    go_d = go_q;
    if (clear_enable) go_d = 1'b0;
    if (ctrl_wr && av_byteenable[0]) go_d = av_writedata[0];

    irq_en_d = irq_en_q;
    for (int k = 1; k <= NO_INTERRUPTS; k++) begin
      if (ctrl_wr && av_byteenable[k/8]) irq_en_d[k] = av_writedata[k];
    end

    // Capture enabled sources, drop disabled bits, then apply W1C last so it wins over a set.
    isr_d = (isr_q | (interrupts & irq_en_q)) & irq_en_q;
    for (int k = 1; k <= NO_INTERRUPTS; k++) begin
      if (isr_wr && av_byteenable[k/8] && av_writedata[k]) isr_d[k] = 1'b0;
    end

`ifdef CSR_SHADOW_EN
    // A write in the commit cycle lands in the shadow after the copy, so it is still pending.
    pending_d = pending_q;
    if (user_wr)     pending_d = 1'b1;
    else if (commit) pending_d = 1'b0;
`else
    pending_d = 1'b0;
`endif

    rdata_d  = rdata_q;
    rvalid_d = av_read;
    if (av_read) begin
      rdata_d = '0;
      case (sel)
        SEL_CTRL:   rdata_d[NO_INTERRUPTS:0] = {irq_en_q, go_q};
        SEL_STATUS: rdata_d[1:0] = {pending_q, &stopped};
        SEL_ISR:    rdata_d[NO_INTERRUPTS:1] = isr_q;
        SEL_USER: begin
          for (int i = 0; i < NO_REGISTERS; i++) begin
            if (user_hit[i]) rdata_d = reg_rd[i];
          end
        end
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      go_q      <= 1'b0;
      irq_en_q  <= '0;
      isr_q     <= '0;
      pending_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      go_q      <= go_d;
      irq_en_q  <= irq_en_d;
      isr_q     <= isr_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  for (genvar i = 0; i < NO_REGISTERS; i++) begin : g_reg
    alt_vipcts131_csr_reg #(
      .W                    (W),
      .ALLOW_INTERNAL_WRITE (ALLOW_INTERNAL_WRITE != 0)
    ) u_reg (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (av_write && user_hit[i]),
      .wr_data  (av_writedata),
      .wr_be    (av_byteenable),
      .int_wr   (registers_write[i]),
      .int_data (registers_in[i*W +: W]),
      .commit   (commit),
      .active   (registers[i*W +: W]),
      .rd_value (reg_rd[i]),
      .trigger  (triggers[i])
    );
  end

  assign av_readdata      = rdata_q;
  assign av_readdatavalid = rvalid_q;
  assign av_irq           = |isr_q;
  assign enable           = go_q;

endmodule

// File: tb/tb_alt_vipcts131_common_avalon_mm_csr_bank.sv
// tb/tb_alt_vipcts131_common_avalon_mm_csr_bank.sv - self-checking bench for the Avalon-MM CSR bank
module tb_alt_vipcts131_common_avalon_mm_csr_bank;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NO = 2;
  localparam int NI = 1;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   av_address;
  logic            av_read;
  logic [DW-1:0]   av_readdata;
  logic            av_readdatavalid;
  logic            av_write;
  logic [DW-1:0]   av_writedata;
  logic [DW/8-1:0] av_byteenable;
  logic            av_irq;
  logic            enable;
  logic            clear_enable;
  logic            commit;
  logic [NR-1:0]   triggers;
  logic [DW*NR-1:0] registers;
  logic [DW*NR-1:0] registers_in;
  logic [NR-1:0]   registers_write;
  logic [NI-1:0]   interrupts;
  logic [NO-1:0]   stopped;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  always #5 clk = ~clk;

  alt_vipcts131_common_avalon_mm_csr_bank #(
    .AV_ADDRESS_WIDTH     (AW),
    .AV_DATA_WIDTH        (DW),
    .NO_OUTPUTS           (NO),
    .NO_INTERRUPTS        (NI),
    .NO_REGISTERS         (NR),
    .ALLOW_INTERNAL_WRITE (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .av_address       (av_address),
    .av_read          (av_read),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .av_write         (av_write),
    .av_writedata     (av_writedata),
    .av_byteenable    (av_byteenable),
    .av_irq           (av_irq),
    .enable           (enable),
    .clear_enable     (clear_enable),
    .commit           (commit),
    .triggers         (triggers),
    .registers        (registers),
    .registers_in     (registers_in),
    .registers_write  (registers_write),
    .interrupts       (interrupts),
    .stopped          (stopped)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_word(input int i);
    return registers[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    av_address    = a;
    av_writedata  = d;
    av_byteenable = be;
    av_write      = 1'b1;
    tick();
    av_write      = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] e, input string tag);
    rd_exp_t x;
    x.tag   = tag;
    x.value = e;
    exp_q.push_back(x);
    av_address = a;
    av_read    = 1'b1;
    tick();
    av_read    = 1'b0;
  endtask

  // Makes master writes visible on the registers output in the shadow build; no-op otherwise.
  task automatic settle();
`ifdef CSR_SHADOW_EN
    commit = 1'b1;
    tick();
    commit = 1'b0;
`endif
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && av_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rdv_spurious", 64'(av_readdatavalid), 64'd0);
      end else begin
        rd_exp_t x;
        x = exp_q.pop_front();
        check(x.tag, 64'(av_readdata), 64'(x.value));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b0;
    av_address      = 5'd3;
    av_read         = 1'b1;
    av_write        = 1'b1;
    av_writedata    = 32'hFFFF_FFFF;
    av_byteenable   = 4'hF;
    clear_enable    = 1'b0;
    commit          = 1'b1;
    registers_in    = '1;
    registers_write = '1;
    interrupts      = '1;
    stopped         = '1;
    repeat (3) tick();
    check("rst_rdv", 64'(av_readdatavalid), 64'd0);
    check("rst_irq", 64'(av_irq), 64'd0);
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_triggers", 64'(triggers), 64'd0);
    check("rst_readdata", 64'(av_readdata), 64'd0);
    check("rst_regs_lo", registers[63:0], 64'd0);
    check("rst_regs_hi", registers[127:64], 64'd0);

    av_read         = 1'b0;
    av_write        = 1'b0;
    commit          = 1'b0;
    registers_in    = '0;
    registers_write = '0;
    interrupts      = '0;
    rst             = 1'b1;
    tick();
    rd(5'd0, 32'h0, "rd_ctrl_after_rst");
    rd(5'd1, 32'h1, "rd_status_stopped");

    wr(5'd3, 32'hAABB_CCDD, 4'b0101);
    check("be_trigger", 64'(triggers), 64'h1);
    tick();
    check("be_trigger_end", 64'(triggers), 64'h0);
    settle();
    check("be_reg0", 64'(reg_word(0)), 64'h00BB_00DD);
    rd(5'd3, 32'h00BB_00DD, "be_rd_reg0");

    wr(5'd4, 32'h1234_5678, 4'hF);
    wr(5'd4, 32'hCAFE_BABE, 4'b1010);
    check("be2_trigger", 64'(triggers), 64'h2);
    settle();
    check("be2_reg1", 64'(reg_word(1)), 64'hCA34_BA78);
    rd(5'd4, 32'hCA34_BA78, "be2_rd_reg1");

    wr(5'd20, 32'hFFFF_FFFF, 4'hF);
    check("oor_trigger", 64'(triggers), 64'h0);
    settle();
    check("oor_reg0", 64'(reg_word(0)), 64'h00BB_00DD);
    check("oor_reg3", 64'(reg_word(3)), 64'h0);
    rd(5'd20, 32'h0, "oor_rd20");
    rd(5'd7, 32'h0, "oor_rd7");

    wr(5'd0, 32'h3, 4'hF);
    check("ctrl_enable", 64'(enable), 64'd1);
    interrupts = 1'b1;
    tick();
    interrupts = 1'b0;
    check("irq_set", 64'(av_irq), 64'd1);
    rd(5'd2, 32'h2, "isr_rd");
    rd(5'd0, 32'h3, "ctrl_rd");
    interrupts    = 1'b1;
    av_address    = 5'd2;
    av_writedata  = 32'h2;
    av_byteenable = 4'h1;
    av_write      = 1'b1;
    tick();
    av_write   = 1'b0;
    interrupts = 1'b0;
    check("w1c_wins", 64'(av_irq), 64'd0);
    rd(5'd2, 32'h0, "isr_rd_cleared");
    interrupts = 1'b1;
    tick();
    interrupts = 1'b0;
    check("irq_set2", 64'(av_irq), 64'd1);
    wr(5'd2, 32'h2, 4'b1110);
    check("w1c_lane_off", 64'(av_irq), 64'd1);
    wr(5'd0, 32'h1, 4'hF);
    tick();
    check("irq_en_off", 64'(av_irq), 64'd0);
    check("irq_en_off_go", 64'(enable), 64'd1);

    clear_enable = 1'b1;
    tick();
    clear_enable = 1'b0;
    check("clear_enable", 64'(enable), 64'd0);
    clear_enable = 1'b1;
    wr(5'd0, 32'h1, 4'h1);
    clear_enable = 1'b0;
    check("go_race", 64'(enable), 64'd1);
    clear_enable = 1'b1;
    tick();
    clear_enable = 1'b0;
    check("go_clear_alone", 64'(enable), 64'd0);
    wr(5'd0, 32'h1, 4'b1110);
    check("go_lane_off", 64'(enable), 64'd0);

    registers_in[63:32] = 32'h22;
    registers_write     = 4'b0010;
    wr(5'd4, 32'h11, 4'hF);
    registers_write     = '0;
    check("int_vs_master_trig", 64'(triggers), 64'h2);
    settle();
    check("int_vs_master", 64'(reg_word(1)), 64'h11);
    registers_write = 4'b0010;
    tick();
    registers_write = '0;
    check("int_only_trig", 64'(triggers), 64'h0);
    settle();
    check("int_only", 64'(reg_word(1)), 64'h22);
    check("int_only_reg0", 64'(reg_word(0)), 64'h00BB_00DD);
    rd(5'd4, 32'h22, "int_rd_reg1");

    stopped = 2'b01;
    rd(5'd1, 32'h0, "status_stopped_partial");
    stopped = 2'b11;
    rd(5'd1, 32'h1, "status_stopped_all");
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("commit_idle_reg0", 64'(reg_word(0)), 64'h00BB_00DD);

`ifdef CSR_SHADOW_EN
    wr(5'd3, 32'h5, 4'hF);
    check("shadow_hidden", 64'(reg_word(0)), 64'h00BB_00DD);
    rd(5'd1, 32'h3, "shadow_pending");
    rd(5'd3, 32'h5, "shadow_rd");
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("shadow_commit", 64'(reg_word(0)), 64'h5);
    rd(5'd1, 32'h1, "shadow_pending_clr");
    commit = 1'b1;
    wr(5'd3, 32'h7, 4'hF);
    commit = 1'b0;
    check("shadow_race_active", 64'(reg_word(0)), 64'h5);
    rd(5'd1, 32'h3, "shadow_race_pending");
    rd(5'd3, 32'h7, "shadow_race_rd");
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("shadow_race_commit", 64'(reg_word(0)), 64'h7);
`else
    wr(5'd3, 32'h5, 4'hF);
    check("direct_write", 64'(reg_word(0)), 64'h5);
    rd(5'd1, 32'h1, "direct_no_pending");
`endif

    tick();
    tick();
    check("rd_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
